// File: rtl/matvec_engine_if.sv
// rtl/matvec_engine_if.sv - word-wide memory read port between matvec_engine and on-chip memory
`timescale 1ns/1ps
interface matvec_engine_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 64
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_waitrequest;
  logic [WORD_W-1:0] mem_readdata;
  logic              mem_readdatavalid;

  modport master (
    output mem_addr, mem_read,
    input  mem_waitrequest, mem_readdata, mem_readdatavalid
  );

  modport slave (
    input  mem_addr, mem_read,
    output mem_waitrequest, mem_readdata, mem_readdatavalid
  );
endinterface

// File: rtl/matvec_engine.sv
// rtl/matvec_engine.sv - matrix-vector MAC engine with per-vector FIFOs (optional saturation: MATVEC_SAT_EN)
`timescale 1ns/1ps
module matvec_engine #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ROWS   = 8,
  parameter int ACC_W  = 24,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  accumulate,
  input  logic [ADDR_W-1:0]     base_addr,
  output logic                  busy,
  output logic                  done,
  output logic [ROWS*ACC_W-1:0] result,
  output logic [ROWS-1:0]       overflow,
  matvec_engine_if.master       mem
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int WI_W  = $clog2(ROWS + 1);
  localparam int NF    = ROWS + 1;
  localparam logic [PTR_W-1:0] LAST_ELEM = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);
  localparam logic [WI_W-1:0]  LAST_WORD = WI_W'(ROWS);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_FILL, S_MAC, S_DONE} state_t;

  state_t                  state;
  logic [ADDR_W-1:0]       base_q;
  logic [WI_W-1:0]         word_idx;
  logic [PTR_W-1:0]        elem_idx;
  logic [DEPTH*DATA_W-1:0] word_buf;
  logic [DATA_W-1:0]       fill_elem;

  // FIFO 0 holds B, FIFO r+1 holds A row r
  logic [DATA_W-1:0] fifo_q [NF][DEPTH];
  logic [PTR_W-1:0]  wr_ptr [NF];
  logic [PTR_W-1:0]  rd_ptr [NF];
  logic [CNT_W-1:0]  count  [NF];
  logic [DATA_W-1:0] head   [NF];
  logic [NF-1:0]     push;
  logic [NF-1:0]     pop;

  logic [ACC_W-1:0]  acc_q [ROWS];
  logic [ACC_W-1:0]  prod  [ROWS];
  logic              clear_acc;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_ELEM) ? '0 : p + PTR_W'(1);
  endfunction

  assign fill_elem = word_buf[elem_idx*DATA_W +: DATA_W];
  assign clear_acc = (state == S_IDLE) && start && !accumulate;

  // Sequencer: word fetch, element fill and MAC pass counting, registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      mem.mem_read <= 1'b0;
      mem.mem_addr <= '0;
      base_q       <= '0;
      word_idx     <= '0;
      elem_idx     <= '0;
      word_buf     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q       <= base_addr;
            word_idx     <= '0;
            elem_idx     <= '0;
            mem.mem_addr <= base_addr;
            mem.mem_read <= 1'b1;
            busy         <= 1'b1;
            state        <= S_REQ;
          end
        end
        S_REQ: begin
          if (!mem.mem_waitrequest) begin
            mem.mem_read <= 1'b0;
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem.mem_readdatavalid) begin
            word_buf <= mem.mem_readdata;
            elem_idx <= '0;
            state    <= S_FILL;
          end
        end
        S_FILL: begin
          if (elem_idx == LAST_ELEM) begin
            elem_idx <= '0;
            if (word_idx < LAST_WORD) begin
              word_idx     <= word_idx + WI_W'(1);
              mem.mem_addr <= base_q + ADDR_W'(word_idx) + ADDR_W'(1);
              mem.mem_read <= 1'b1;
              state        <= S_REQ;
            end else begin
              state <= S_MAC;
            end
          end else begin
            elem_idx <= elem_idx + PTR_W'(1);
          end
        end
        S_MAC: begin
          if (elem_idx == LAST_ELEM) begin
            elem_idx <= '0;
            done     <= 1'b1;
            state    <= S_DONE;
          end else begin
            elem_idx <= elem_idx + PTR_W'(1);
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Push/pop strobes guarded by FIFO occupancy, plus FIFO heads and lane products
  always_comb begin
    for (int f = 0; f < NF; f++) begin
      push[f] = (state == S_FILL) && (word_idx == WI_W'(f)) && (count[f] != FULL);
      pop[f]  = (state == S_MAC) && (count[f] != '0);
      head[f] = fifo_q[f][rd_ptr[f]];
    end
    for (int r = 0; r < ROWS; r++) begin
      prod[r] = ACC_W'(head[r+1]) * ACC_W'(head[0]);
    end
  end

  // FIFO storage, pointers and occupancy counters
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int f = 0; f < NF; f++) begin
        wr_ptr[f] <= '0;
        rd_ptr[f] <= '0;
        count[f]  <= '0;
      end
    end else begin
      for (int f = 0; f < NF; f++) begin
        if (push[f]) begin
          fifo_q[f][wr_ptr[f]] <= fill_elem;
          wr_ptr[f]            <= ptr_inc(wr_ptr[f]);
        end
        if (pop[f]) begin
          rd_ptr[f] <= ptr_inc(rd_ptr[f]);
        end
        case ({push[f], pop[f]})
          2'b10:   count[f] <= count[f] + CNT_W'(1);
          2'b01:   count[f] <= count[f] - CNT_W'(1);
          default: count[f] <= count[f];
        endcase
      end
    end
  end

`ifdef MATVEC_SAT_EN
  logic [ACC_W:0]  sum [ROWS];
  logic [ROWS-1:0] ovf_q;

  // One extra bit catches the carry that triggers saturation
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      sum[r] = {1'b0, acc_q[r]} + {1'b0, prod[r]};
    end
  end

  // Saturating accumulators with sticky per-row overflow
  always_ff @(posedge clk) begin
    if (rst || clear_acc) begin
      for (int r = 0; r < ROWS; r++) acc_q[r] <= '0;
      ovf_q <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        if (pop[0] && pop[r+1]) begin
          if (sum[r][ACC_W]) begin
            acc_q[r] <= '1;
            ovf_q[r] <= 1'b1;
          end else begin
            acc_q[r] <= sum[r][ACC_W-1:0];
          end
        end
      end
    end
  end

  assign overflow = ovf_q;
`else
  // Wrapping accumulators
  always_ff @(posedge clk) begin
    if (rst || clear_acc) begin
      for (int r = 0; r < ROWS; r++) acc_q[r] <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        if (pop[0] && pop[r+1]) acc_q[r] <= acc_q[r] + prod[r];
      end
    end
  end

  assign overflow = '0;
`endif

  for (genvar r = 0; r < ROWS; r++) begin : g_result
    assign result[r*ACC_W +: ACC_W] = acc_q[r];
  end

endmodule

// File: tb/tb_matvec_engine.sv
// tb/tb_matvec_engine.sv - table-driven bench for matvec_engine with a stalling memory model
`timescale 1ns/1ps
module tb_matvec_engine;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int ROWS   = 8;
  localparam int ACC_W  = 24;
  localparam int ACC_B  = 16;
  localparam int ADDR_W = 32;
  localparam int WORD_W = DEPTH * DATA_W;

  typedef struct {
    logic [31:0] base;
    logic        acc;
    int          stall;
    int          lat;
    int          r0;
    int          step;
    int          done_cyc;
    int          extra;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic                  start_a, acc_a, start_b, acc_b;
  logic [ADDR_W-1:0]     base_a, base_b;
  logic                  busy_a, done_a, busy_b, done_b;
  logic [ROWS*ACC_W-1:0] result_a;
  logic [ROWS*ACC_B-1:0] result_b;
  logic [ROWS-1:0]       ovf_a, ovf_b;

  matvec_engine_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus_a ();
  matvec_engine_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus_b ();

  matvec_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ROWS(ROWS), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .accumulate(acc_a), .base_addr(base_a),
    .busy(busy_a), .done(done_a), .result(result_a), .overflow(ovf_a), .mem(bus_a)
  );

  matvec_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ROWS(ROWS), .ACC_W(ACC_B), .ADDR_W(ADDR_W)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .accumulate(acc_b), .base_addr(base_b),
    .busy(busy_b), .done(done_b), .result(result_b), .overflow(ovf_b), .mem(bus_b)
  );

  logic [WORD_W-1:0] mem [0:127];
  logic              wreq, rvalid;
  logic [WORD_W-1:0] rdata;
  logic              use_b;
  logic              m_read;
  logic [ADDR_W-1:0] m_addr;

  assign bus_a.mem_waitrequest   = wreq;
  assign bus_a.mem_readdata      = rdata;
  assign bus_a.mem_readdatavalid = rvalid;
  assign bus_b.mem_waitrequest   = wreq;
  assign bus_b.mem_readdata      = rdata;
  assign bus_b.mem_readdatavalid = rvalid;
  assign m_read = use_b ? bus_b.mem_read : bus_a.mem_read;
  assign m_addr = use_b ? bus_b.mem_addr : bus_a.mem_addr;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0, due = 0, stall_left = 0, stall_cfg = 0, lat_cfg = 1, req_no = 0;
  logic [31:0] cur_base, pend_addr;
  bit in_req = 1'b0, pend = 1'b0;
  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Memory slave: stall_cfg waitrequest cycles per request, data lat_cfg cycles after accept
  always @(posedge clk) begin
    #2;
    cyc++;
    rvalid = 1'b0;
    rdata  = 64'hA5A5_5A5A_DEAD_BEEF;
    if (rst) begin
      in_req = 1'b0;
      pend   = 1'b0;
      wreq   = 1'b0;
    end else begin
      if (pend && cyc == due) begin
        rvalid = 1'b1;
        rdata  = mem[pend_addr[6:0]];
        pend   = 1'b0;
      end
      if (in_req) check("mem_read_held", {63'd0, m_read}, 64'd1);
      if (m_read) begin
        check($sformatf("mem_addr_w%0d", req_no), {32'd0, m_addr}, {32'd0, cur_base + 32'(req_no)});
        if (!in_req) begin
          in_req     = 1'b1;
          stall_left = stall_cfg;
        end
        if (stall_left > 0) begin
          wreq = 1'b1;
          stall_left--;
        end else begin
          wreq      = 1'b0;
          in_req    = 1'b0;
          pend      = 1'b1;
          due       = cyc + lat_cfg;
          pend_addr = m_addr;
          req_no++;
        end
      end else begin
        wreq   = 1'b0;
        in_req = 1'b0;
      end
    end
  end

  task automatic run_a(input vec_t v, input int idx);
    int done_at, done_cnt, busy_bad, limit;
    stall_cfg = v.stall;
    lat_cfg   = v.lat;
    cur_base  = v.base;
    req_no    = 0;
    @(negedge clk);
    start_a = 1'b1;
    acc_a   = v.acc;
    base_a  = v.base;
    @(negedge clk);
    start_a  = 1'b0;
    done_at  = 0;
    done_cnt = 0;
    busy_bad = 0;
    limit    = v.done_cyc + 4;
    for (int n = 1; n <= limit; n++) begin
      if (done_a) begin
        done_cnt++;
        if (done_at == 0) done_at = n;
      end
      if (busy_a !== (n <= v.done_cyc)) busy_bad++;
      start_a = (v.extra != 0) && ((n == v.extra) || done_a);
      @(negedge clk);
    end
    start_a = 1'b0;
    check($sformatf("v%0d_done_cycle", idx), 64'(done_at), 64'(v.done_cyc));
    check($sformatf("v%0d_done_pulses", idx), 64'(done_cnt), 64'd1);
    check($sformatf("v%0d_busy_window", idx), 64'(busy_bad), 64'd0);
    for (int r = 0; r < ROWS; r++) begin
      check($sformatf("v%0d_row%0d", idx, r), {40'd0, result_a[r*ACC_W +: ACC_W]}, 64'(v.r0 + r * v.step));
    end
    check($sformatf("v%0d_overflow", idx), {56'd0, ovf_a}, 64'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    for (int k = 0; k < DEPTH; k++) begin
      mem[16][8*k +: 8] = 8'(k + 1);
      mem[48][8*k +: 8] = 8'd2;
      for (int r = 0; r < ROWS; r++) begin
        mem[17+r][8*k +: 8] = 8'(8*r + k + 1);
        mem[49+r][8*k +: 8] = 8'(r + 1);
      end
    end
    for (int i = 80; i <= 88; i++) mem[i] = '1;

    //         base  acc   stall lat  r0   step done extra
    vecs[0] = '{32'd16, 1'b0, 0, 1, 204, 288, 99,  0};
    vecs[1] = '{32'd16, 1'b1, 0, 1, 408, 576, 99,  0};
    vecs[2] = '{32'd16, 1'b0, 3, 4, 204, 288, 153, 0};
    vecs[3] = '{32'd48, 1'b0, 1, 2, 16,  16,  117, 0};
    vecs[4] = '{32'd16, 1'b0, 0, 1, 204, 288, 99,  93};
    vecs[5] = '{32'd48, 1'b1, 0, 1, 220, 304, 99,  0};

    rst = 1'b1;
    start_a = 1'b0; acc_a = 1'b0; base_a = '0;
    start_b = 1'b0; acc_b = 1'b0; base_b = '0;
    use_b = 1'b0; cur_base = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {63'd0, busy_a}, 64'd0);
    check("rst_done", {63'd0, done_a}, 64'd0);
    check("rst_mem_read", {63'd0, bus_a.mem_read}, 64'd0);
    check("rst_mem_addr", {32'd0, bus_a.mem_addr}, 64'd0);
    check("rst_result_lo", result_a[63:0], 64'd0);
    check("rst_result_hi", {{(256-ROWS*ACC_W){1'b0}}, result_a} >> 64, 64'd0);
    check("rst_overflow", {56'd0, ovf_a}, 64'd0);
    check("rst_busy_b", {63'd0, busy_b}, 64'd0);

    for (int i = 0; i < 6; i++) run_a(vecs[i], i);

    // Reset while a request is stalled: mem_read must drop at the reset edge
    stall_cfg = 3; lat_cfg = 1; cur_base = 32'd16; req_no = 0;
    @(negedge clk); start_a = 1'b1; acc_a = 1'b0; base_a = 32'd16;
    @(negedge clk); start_a = 1'b0;
    @(negedge clk);
    check("req_mem_read_before_rst", {63'd0, bus_a.mem_read}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("req_rst_mem_read", {63'd0, bus_a.mem_read}, 64'd0);
    check("req_rst_busy", {63'd0, busy_a}, 64'd0);
    rst = 1'b0;

    // Reset during FILL of A row 3 (cycles 43..50), then a clean rerun
    stall_cfg = 0; lat_cfg = 1; cur_base = 32'd16; req_no = 0;
    @(negedge clk); start_a = 1'b1; acc_a = 1'b0; base_a = 32'd16;
    @(negedge clk); start_a = 1'b0;
    repeat (44) @(negedge clk);
    check("fill_busy_before_rst", {63'd0, busy_a}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("fill_rst_busy", {63'd0, busy_a}, 64'd0);
    check("fill_rst_mem_read", {63'd0, bus_a.mem_read}, 64'd0);
    check("fill_rst_mem_addr", {32'd0, bus_a.mem_addr}, 64'd0);
    check("fill_rst_result", result_a[63:0], 64'd0);
    repeat (5) @(negedge clk);
    check("fill_rst_idle_done", {63'd0, done_a}, 64'd0);
    check("fill_rst_idle_busy", {63'd0, busy_a}, 64'd0);
    check("fill_rst_row7", {40'd0, result_a[7*ACC_W +: ACC_W]}, 64'd0);
    run_a(vecs[0], 6);

    // 16-bit accumulators with all-0xFF data: wrap or saturate
    use_b = 1'b1; stall_cfg = 0; lat_cfg = 1; cur_base = 32'd80; req_no = 0;
    @(negedge clk); start_b = 1'b1; acc_b = 1'b0; base_b = 32'd80;
    @(negedge clk); start_b = 1'b0;
    n = 1;
    while (!done_b && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("b_done_cycle", 64'(n), 64'd99);
    for (int r = 0; r < ROWS; r++) begin
`ifdef MATVEC_SAT_EN
      check($sformatf("b_row%0d", r), {48'd0, result_b[r*ACC_B +: ACC_B]}, 64'd65535);
`else
      check($sformatf("b_row%0d", r), {48'd0, result_b[r*ACC_B +: ACC_B]}, 64'd61448);
`endif
    end
`ifdef MATVEC_SAT_EN
    check("b_overflow", {56'd0, ovf_b}, 64'hFF);
`else
    check("b_overflow", {56'd0, ovf_b}, 64'd0);
`endif
    @(negedge clk);
    use_b = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
